// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the cartridge SRAM arbiter.
// The counter width covers the largest legal access length.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CART,
    UC
  } state_t;

  localparam int ACC_CYCLES_DEF = 4;
  localparam int ACC_MAX = 15;
  localparam int CNT_W = $clog2(ACC_MAX + 1);

endpackage

// File: rtl/sram_cycle_seq.sv
// One fixed-length SRAM access: cycle counter and registered strobes.
// Strobes are computed from the next state so pins change on the edge.
module sram_cycle_seq
  import sram_arb_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic we,
  output logic last,
  output logic capture,
  output logic oe_n,
  output logic we_n,
  output logic dout_en
);

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(ACC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(ACC_CYCLES - 2);

  logic active;
  logic wr;
  logic [CNT_W-1:0] cnt;

  logic nxt_active;
  logic nxt_wr;
  logic [CNT_W-1:0] nxt_cnt;

  assign last = active && (cnt == LAST_C);
  assign capture = active && !wr && (cnt == CAP_C);

  always_comb begin
    nxt_active = active;
    nxt_wr = wr;
    nxt_cnt = cnt;
    if (start) begin
      nxt_active = 1'b1;
      nxt_wr = we;
      nxt_cnt = '0;
    end else if (last) begin
      nxt_active = 1'b0;
      nxt_cnt = '0;
    end else if (active) begin
      nxt_cnt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      wr <= 1'b0;
      cnt <= '0;
      oe_n <= 1'b1;
      we_n <= 1'b1;
      dout_en <= 1'b0;
    end else begin
      active <= nxt_active;
      wr <= nxt_wr;
      cnt <= nxt_cnt;
      oe_n <= !(nxt_active && !nxt_wr);
      // write pulse leaves one cycle of address setup and hold
      we_n <= !(nxt_active && nxt_wr &&
                (nxt_cnt != '0) && (nxt_cnt <= CAP_C));
      dout_en <= nxt_active && nxt_wr;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the single SRAM port between the cart bus and the uC.
// Cart has priority; a started access always runs to completion.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cart_req,
  input  logic              cart_we,
  input  logic [ADDR_W-1:0] cart_addr,
  input  logic [DATA_W-1:0] cart_wdata,
  output logic [DATA_W-1:0] cart_rdata,
  output logic              cart_done,
  output logic              cart_overrun,
  input  logic              uc_req,
  input  logic              uc_we,
  input  logic [ADDR_W-1:0] uc_addr,
  input  logic [DATA_W-1:0] uc_wdata,
  input  logic              uc_inhibit,
  output logic [DATA_W-1:0] uc_rdata,
  output logic              uc_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_dout_en,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              busy
);

  state_t state;

  logic              pend;
  logic              pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;

  logic last;
  logic capture;
  logic can_grant;
  logic take_pend;
  logic direct;
  logic cart_go;
  logic uc_go;
  logic start;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign can_grant = (state == IDLE) || last;
  assign take_pend = can_grant && pend;
  assign direct = can_grant && !pend && cart_req;
  assign cart_go = take_pend || direct;
  // the uC request that just finished must not be re-granted
  assign uc_go = can_grant && !cart_go && (state != UC) &&
                 uc_req && !uc_ack && !uc_inhibit;
  assign start = cart_go || uc_go;

  always_comb begin
    sel_we = uc_we;
    sel_addr = uc_addr;
    sel_wdata = uc_wdata;
    unique case (1'b1)
      take_pend: begin
        sel_we = pend_we;
        sel_addr = pend_addr;
        sel_wdata = pend_wdata;
      end
      direct: begin
        sel_we = cart_we;
        sel_addr = cart_addr;
        sel_wdata = cart_wdata;
      end
      default: ;
    endcase
  end

  sram_cycle_seq #(
    .ACC_CYCLES(ACC_CYCLES)
  ) u_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .we     (sel_we),
    .last   (last),
    .capture(capture),
    .oe_n   (ram_oe),
    .we_n   (ram_we),
    .dout_en(ram_dout_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      pend <= 1'b0;
      pend_we <= 1'b0;
      pend_addr <= '0;
      pend_wdata <= '0;
      ram_addr <= '0;
      ram_dout <= '0;
      cart_rdata <= '0;
      uc_rdata <= '0;
      cart_done <= 1'b0;
      cart_overrun <= 1'b0;
      uc_ack <= 1'b0;
    end else begin
      cart_done <= (state == CART) && last;

      if ((state == UC) && last) begin
        uc_ack <= 1'b1;
      end else if (!uc_req) begin
        uc_ack <= 1'b0;
      end

      if (capture) begin
        if (state == CART) begin
          cart_rdata <= ram_din;
        end else begin
          uc_rdata <= ram_din;
        end
      end

      if (start) begin
        ram_addr <= sel_addr;
        if (sel_we) begin
          ram_dout <= sel_wdata;
        end
        state <= cart_go ? CART : UC;
        busy <= 1'b1;
      end else if (last) begin
        state <= IDLE;
        busy <= 1'b0;
      end

      // a newer cart request always replaces an unserved older one
      if (cart_req && !direct) begin
        pend <= 1'b1;
        pend_we <= cart_we;
        pend_addr <= cart_addr;
        pend_wdata <= cart_wdata;
        if (pend && !take_pend) begin
          cart_overrun <= 1'b1;
        end
      end else if (take_pend) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed and randomized checks of the SRAM arbiter against a
// behavioural SRAM and a transaction-level shadow memory.
module tb_sram_access_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cart_req;
  logic          cart_we;
  logic [AW-1:0] cart_addr;
  logic [DW-1:0] cart_wdata;
  logic [DW-1:0] cart_rdata;
  logic          cart_done;
  logic          cart_overrun;
  logic          uc_req;
  logic          uc_we;
  logic [AW-1:0] uc_addr;
  logic [DW-1:0] uc_wdata;
  logic          uc_inhibit;
  logic [DW-1:0] uc_rdata;
  logic          uc_ack;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          ram_dout_en;
  logic [DW-1:0] ram_din;
  logic          ram_oe;
  logic          ram_we;
  logic          busy;

  int checks = 0;
  int errors = 0;

  sram_access_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .ACC_CYCLES(N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cart_req    (cart_req),
    .cart_we     (cart_we),
    .cart_addr   (cart_addr),
    .cart_wdata  (cart_wdata),
    .cart_rdata  (cart_rdata),
    .cart_done   (cart_done),
    .cart_overrun(cart_overrun),
    .uc_req      (uc_req),
    .uc_we       (uc_we),
    .uc_addr     (uc_addr),
    .uc_wdata    (uc_wdata),
    .uc_inhibit  (uc_inhibit),
    .uc_rdata    (uc_rdata),
    .uc_ack      (uc_ack),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout),
    .ram_dout_en (ram_dout_en),
    .ram_din     (ram_din),
    .ram_oe      (ram_oe),
    .ram_we      (ram_we),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // asynchronous-read SRAM, written while the write strobe is low
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign ram_din = mem[ram_addr];
  always @(posedge clk) begin
    if (!ram_we && ram_dout_en) mem[ram_addr] <= ram_dout;
  end

  int   mon_we_low = 0;
  int   mon_oe_low = 0;
  int   mon_den = 0;
  logic prev_den = 1'b0;
  logic prev_we = 1'b1;
  logic we_first = 1'b0;
  logic we_last = 1'b0;

  always @(negedge clk) begin
    if (!ram_we) mon_we_low <= mon_we_low + 1;
    if (!ram_oe) mon_oe_low <= mon_oe_low + 1;
    if (ram_dout_en) mon_den <= mon_den + 1;
    if (ram_dout_en && !prev_den) we_first <= ram_we;
    if (!ram_dout_en && prev_den) we_last <= prev_we;
    prev_den <= ram_dout_en;
    prev_we <= ram_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cart_op(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat,
                         output logic [DW-1:0] rd);
    cart_req = 1'b1;
    cart_we = we;
    cart_addr = a;
    cart_wdata = d;
    step();
    cart_req = 1'b0;
    lat = 0;
    while (!cart_done && lat < 40) begin
      step();
      lat++;
    end
    rd = cart_rdata;
  endtask

  task automatic uc_op(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int lat,
                       output logic [DW-1:0] rd);
    int k;
    uc_req = 1'b1;
    uc_we = we;
    uc_addr = a;
    uc_wdata = d;
    step();
    lat = 0;
    while (!uc_ack && lat < 40) begin
      step();
      lat++;
    end
    rd = uc_rdata;
    uc_req = 1'b0;
    k = 0;
    while (uc_ack && k < 10) begin
      step();
      k++;
    end
    chk("uc_ack_drop", {31'd0, uc_ack}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int            lat;
  int            tc;
  int            tu;
  int            s_we;
  int            s_oe;
  int            s_den;
  logic [DW-1:0] rd;
  logic [AW-1:0] addrs [8];
  logic [DW-1:0] sh [8];
  int            k;
  logic          w;
  logic [DW-1:0] d;
  logic          use_uc;

  initial begin
    rst = 1'b1;
    cart_req = 1'b0;
    cart_we = 1'b0;
    cart_addr = '0;
    cart_wdata = '0;
    uc_req = 1'b0;
    uc_we = 1'b0;
    uc_addr = '0;
    uc_wdata = '0;
    uc_inhibit = 1'b0;
    step();
    step();
    chk("rst_oe", {31'd0, ram_oe}, 32'd1);
    chk("rst_we", {31'd0, ram_we}, 32'd1);
    chk("rst_den", {31'd0, ram_dout_en}, 32'd0);
    chk("rst_addr", {17'd0, ram_addr}, 32'd0);
    chk("rst_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_crd", {24'd0, cart_rdata}, 32'd0);
    chk("rst_urd", {24'd0, uc_rdata}, 32'd0);
    chk("rst_done", {31'd0, cart_done}, 32'd0);
    chk("rst_ovr", {31'd0, cart_overrun}, 32'd0);
    chk("rst_ack", {31'd0, uc_ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();
    step();

    // cart read: 4 cycles of oe low, latency N
    uc_op(1'b1, 15'h1234, 8'hA5, lat, rd);
    chk("uc_wr_lat", lat, N);
    s_oe = mon_oe_low;
    cart_op(1'b0, 15'h1234, 8'h00, lat, rd);
    chk("c_rd_lat", lat, N);
    chk("c_rd_data", {24'd0, rd}, 32'hA5);
    chk("c_rd_oe", mon_oe_low - s_oe, N);
    step();
    chk("c_done_pulse", {31'd0, cart_done}, 32'd0);

    // cart write: strobe shape
    s_we = mon_we_low;
    s_den = mon_den;
    cart_op(1'b1, 15'h7FFF, 8'h5A, lat, rd);
    chk("c_wr_lat", lat, N);
    chk("c_wr_welow", mon_we_low - s_we, N - 2);
    chk("c_wr_den", mon_den - s_den, N);
    chk("c_wr_we_first", {31'd0, we_first}, 32'd1);
    chk("c_wr_we_last", {31'd0, we_last}, 32'd1);
    uc_op(1'b0, 15'h7FFF, 8'h00, lat, rd);
    chk("c_wr_readback", {24'd0, rd}, 32'h5A);

    // simultaneous requests: cart first, uc back-to-back
    cart_req = 1'b1;
    cart_we = 1'b0;
    cart_addr = 15'h1234;
    uc_req = 1'b1;
    uc_we = 1'b0;
    uc_addr = 15'h7FFF;
    step();
    cart_req = 1'b0;
    tc = -1;
    tu = -1;
    for (int t = 1; t <= 30; t++) begin
      step();
      if (cart_done && tc < 0) tc = t;
      if (uc_ack && tu < 0) tu = t;
    end
    chk("both_cart_lat", tc, N);
    chk("both_uc_lat", tu, 2 * N);
    chk("both_cart_data", {24'd0, cart_rdata}, 32'hA5);
    chk("both_uc_data", {24'd0, uc_rdata}, 32'h5A);
    uc_req = 1'b0;
    step();
    step();
    chk("both_ack_drop", {31'd0, uc_ack}, 32'd0);

    // cart arrives just after a uc access started: worst case
    uc_req = 1'b1;
    uc_we = 1'b0;
    uc_addr = 15'h1234;
    step();
    chk("wc_busy", {31'd0, busy}, 32'd1);
    cart_req = 1'b1;
    cart_we = 1'b0;
    cart_addr = 15'h7FFF;
    step();
    cart_req = 1'b0;
    tc = -1;
    tu = -1;
    for (int t = 1; t <= 20; t++) begin
      if (uc_ack && tu < 0) tu = t - 1;
      step();
      if (cart_done && tc < 0) tc = t;
    end
    chk("wc_uc_lat", tu, N - 1);
    chk("wc_cart_lat", tc, 2 * N - 1);
    chk("wc_uc_data", {24'd0, uc_rdata}, 32'hA5);
    chk("wc_cart_data", {24'd0, cart_rdata}, 32'h5A);
    chk("wc_ovr", {31'd0, cart_overrun}, 32'd0);
    uc_req = 1'b0;
    step();
    step();

    // two cart requests during one uc access: overrun
    cart_op(1'b1, 15'h0100, 8'h11, lat, rd);
    cart_op(1'b1, 15'h0200, 8'h22, lat, rd);
    uc_req = 1'b1;
    uc_we = 1'b1;
    uc_addr = 15'h0300;
    uc_wdata = 8'h33;
    step();
    cart_req = 1'b1;
    cart_we = 1'b1;
    cart_addr = 15'h0100;
    cart_wdata = 8'hEE;
    step();
    cart_req = 1'b0;
    step();
    cart_req = 1'b1;
    cart_addr = 15'h0200;
    cart_wdata = 8'hDD;
    step();
    cart_req = 1'b0;
    lat = 0;
    while (!cart_done && lat < 40) begin
      step();
      lat++;
    end
    chk("ovr_done_seen", {31'd0, cart_done}, 32'd1);
    chk("ovr_set", {31'd0, cart_overrun}, 32'd1);
    uc_req = 1'b0;
    step();
    step();
    uc_op(1'b0, 15'h0100, 8'h00, lat, rd);
    chk("ovr_old_kept", {24'd0, rd}, 32'h11);
    uc_op(1'b0, 15'h0200, 8'h00, lat, rd);
    chk("ovr_new_written", {24'd0, rd}, 32'hDD);
    uc_op(1'b0, 15'h0300, 8'h00, lat, rd);
    chk("ovr_uc_written", {24'd0, rd}, 32'h33);

    // uc_inhibit holds off new uc accesses
    uc_inhibit = 1'b1;
    uc_req = 1'b1;
    uc_we = 1'b0;
    uc_addr = 15'h0300;
    for (int t = 0; t < 10; t++) step();
    chk("inh_ack", {31'd0, uc_ack}, 32'd0);
    chk("inh_busy", {31'd0, busy}, 32'd0);
    uc_inhibit = 1'b0;
    uc_req = 1'b0;
    uc_op(1'b0, 15'h0300, 8'h00, lat, rd);
    chk("inh_lat", lat, N);
    chk("inh_data", {24'd0, rd}, 32'h33);

    // randomized traffic against a shadow memory
    for (int i = 0; i < 8; i++) begin
      addrs[i] = {3'(i), 12'($urandom)};
      sh[i] = 8'($urandom);
      cart_op(1'b1, addrs[i], sh[i], lat, rd);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(7);
      w = 1'($urandom_range(1));
      d = 8'($urandom);
      use_uc = 1'($urandom_range(1));
      if (use_uc) uc_op(w, addrs[k], d, lat, rd);
      else cart_op(w, addrs[k], d, lat, rd);
      chk(use_uc ? "rnd_uc_lat" : "rnd_cart_lat", lat, N);
      if (w) sh[k] = d;
      else chk(use_uc ? "rnd_uc_data" : "rnd_cart_data",
               {24'd0, rd}, {24'd0, sh[k]});
      step();
    end
    chk("ovr_sticky", {31'd0, cart_overrun}, 32'd1);

    // asynchronous reset in the middle of a write
    cart_req = 1'b1;
    cart_we = 1'b1;
    cart_addr = 15'h0400;
    cart_wdata = 8'h44;
    step();
    cart_req = 1'b0;
    step();
    step();
    chk("mid_we_low", {31'd0, ram_we}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, ram_we}, 32'd1);
    chk("arst_den", {31'd0, ram_dout_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ovr", {31'd0, cart_overrun}, 32'd0);
    #1;
    rst = 1'b0;
    step();
    chk("post_ack", {31'd0, uc_ack}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    cart_op(1'b0, 15'h1234, 8'h00, lat, rd);
    chk("post_lat", lat, N);
    chk("post_data", {24'd0, rd}, 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
